// File: rtl/letter_scroll_pkg.sv
// rtl/letter_scroll_pkg.sv - shared types and constants for the letter scroll sequencer
package letter_scroll_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } scroll_state_t;

  localparam int         MSG_LEN    = 16;
  localparam int         OFS_W      = $clog2(MSG_LEN);
  localparam logic [3:0] BLANK_CODE = 4'hF;

endpackage

// File: rtl/letter_scroll_seq_tick_div.sv
// rtl/letter_scroll_seq_tick_div.sv - enabled prescaler with sync clear and terminal-count tick
module tick_div #(
  parameter int DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CW'(DIV - 1));

  // Next count: clear has priority, terminal count rolls over, otherwise count when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_o) cnt_d = '0;
    else if (en_i)   cnt_d = cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/letter_scroll_seq.sv
// rtl/letter_scroll_seq.sv - scrolling message index and digit-select sequencer for a 7-seg letter decoder
// Optional: LETTER_SCROLL_REV_EN adds input dir for reverse scrolling.
module letter_scroll_seq
  import letter_scroll_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STEP_DIV   = 25_000_000,
  parameter int MUX_DIV    = 50_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
`ifdef LETTER_SCROLL_REV_EN
  input  logic                  dir,
`endif
  output logic [3:0]            bin,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  running,
  output logic                  wrap
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  scroll_state_t           state_q, state_d;
  logic [OFS_W-1:0]        offset_q, offset_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [3:0]              bin_q, bin_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    wrap_q, wrap_d;
  logic                    step_tick, mux_tick;

  // Step prescaler only runs in RUN and is cleared by any (re)start.
  tick_div #(.DIV(STEP_DIV)) u_step_div (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (state_q == RUN),
    .clr_i  (start),
    .tick_o (step_tick)
  );

  // Digit mux prescaler free-runs so the display keeps scanning in every state.
  tick_div #(.DIV(MUX_DIV)) u_mux_div (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (1'b1),
    .clr_i  (1'b0),
    .tick_o (mux_tick)
  );

  // FSM next state: start always lands in RUN and masks a simultaneous pause.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (start) state_d = RUN;
               else if (pause) state_d = PAUSE;
      PAUSE:   if (start || pause) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Offset, wrap pulse and digit index; restart beats a coincident step tick.
  always_comb begin
    offset_d = offset_q;
    wrap_d   = 1'b0;
    idx_d    = idx_q;
    if (start) begin
      offset_d = '0;
    end else if (step_tick) begin
`ifdef LETTER_SCROLL_REV_EN
      if (dir) begin
        offset_d = offset_q - OFS_W'(1);
        wrap_d   = (offset_q == '0);
      end else begin
        offset_d = offset_q + OFS_W'(1);
        wrap_d   = (offset_q == '1);
      end
`else
      offset_d = offset_q + OFS_W'(1);
      wrap_d   = (offset_q == '1);
`endif
    end
    if (mux_tick) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
  end

  // Display outputs change together, only at a dwell boundary, so a new offset never appears mid-dwell.
  always_comb begin
    bin_d = bin_q;
    sel_d = sel_q;
    if (state_q == IDLE) begin
      bin_d = BLANK_CODE;
      sel_d = '1;
    end else if (mux_tick) begin
      sel_d = ~(NUM_DIGITS'(1) << idx_q);
      bin_d = offset_q + 4'(idx_q);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      offset_q <= '0;
      idx_q    <= '0;
      bin_q    <= BLANK_CODE;
      sel_q    <= '1;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      idx_q    <= idx_d;
      bin_q    <= bin_d;
      sel_q    <= sel_d;
      wrap_q   <= wrap_d;
    end
  end

  assign bin       = bin_q;
  assign digit_sel = sel_q;
  assign wrap      = wrap_q;
  assign running   = (state_q == RUN);

endmodule

// File: tb/tb_letter_scroll_seq.sv
// tb/tb_letter_scroll_seq.sv - directed self-checking bench for letter_scroll_seq
module tb_letter_scroll_seq;

  logic       clk = 1'b0;
  logic       rst, start, pause;
  logic [3:0] bin, digit_sel;
  logic       running, wrap;
`ifdef LETTER_SCROLL_REV_EN
  logic       dir;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic       s;
    logic       p;
    logic [3:0] bin;
    logic [3:0] sel;
    logic       run;
    logic       wrap;
  } vec_t;

  vec_t tbl[16];

  always #5 clk = ~clk;

  letter_scroll_seq #(.NUM_DIGITS(4), .STEP_DIV(4), .MUX_DIV(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
`ifdef LETTER_SCROLL_REV_EN
    .dir       (dir),
`endif
    .bin       (bin),
    .digit_sel (digit_sel),
    .running   (running),
    .wrap      (wrap)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  task automatic cycle(input logic s, input logic p);
    start = s;
    pause = p;
    @(posedge clk);
    #1;
    start = 1'b0;
    pause = 1'b0;
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_bin"}, 32'(bin), 32'hF);
    chk({tag, "_sel"}, 32'(digit_sel), 32'hF);
    chk({tag, "_run"}, 32'(running), 32'd0);
    chk({tag, "_wrap"}, 32'(wrap), 32'd0);
  endtask

  // Digit shown in cycle k for this bench's reset alignment (mux edges on even cycles).
  function automatic int scan_digit(input int k);
    int e;
    e = (k % 2 == 0) ? k : k - 1;
    return ((e - 1) / 2) % 4;
  endfunction

  initial begin
    int s0;
    rst   = 1'b1;
    start = 1'b0;
    pause = 1'b0;
`ifdef LETTER_SCROLL_REV_EN
    dir   = 1'b0;
`endif
    tbl[0]  = '{1'b1, 1'b0, 4'hF, 4'b1111, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'h2, 4'b1011, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'h2, 4'b1011, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'h3, 4'b0111, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'h3, 4'b0111, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'h1, 4'b1110, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'h1, 4'b1110, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'h2, 4'b1101, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'h2, 4'b1101, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'h4, 4'b1011, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 4'h4, 4'b1011, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 4'h5, 4'b0111, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 4'h5, 4'b0111, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 4'h3, 4'b1110, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 4'h3, 4'b1110, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 4'h4, 4'b1101, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    chk_dark("reset");
    rst = 1'b0;

    // Idle: display dark for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0);
      chk_dark("idle");
    end

    // Start and first scan/step window from the vector table.
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].s, tbl[i].p);
      chk("vec_bin", 32'(bin), 32'(tbl[i].bin));
      chk("vec_sel", 32'(digit_sel), 32'(tbl[i].sel));
      chk("vec_run", 32'(running), 32'(tbl[i].run));
      chk("vec_wrap", 32'(wrap), 32'(tbl[i].wrap));
    end

    // Full message lap: single wrap pulse when offset rolls 15->0.
    while (cyc < 100) begin
      cycle(1'b0, 1'b0);
      chk("lap_wrap", 32'(wrap), 32'(cyc == 85));
      if (cyc == 80) begin
        chk("ofs14_d3_bin", 32'(bin), 32'h1);
        chk("ofs14_d3_sel", 32'(digit_sel), 32'b0111);
      end
    end

    // Pause at offset 5: window frozen, scanning continues.
    while (cyc < 105) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    chk("pause_run", 32'(running), 32'd0);
    while (cyc < 145) begin
      cycle(1'b0, 1'b0);
      chk("pause_bin", 32'(bin), 32'((5 + scan_digit(cyc)) % 16));
      chk("pause_sel", 32'(digit_sel), 32'(4'hF & ~(4'h1 << scan_digit(cyc))));
      chk("pause_run", 32'(running), 32'd0);
    end
    cycle(1'b0, 1'b1);
    chk("resume_run", 32'(running), 32'd1);
    while (cyc < 150) begin
      cycle(1'b0, 1'b0);
      if (cyc == 148) begin
        chk("resume_bin148", 32'(bin), 32'h6);
        chk("resume_sel148", 32'(digit_sel), 32'b1101);
      end
      if (cyc == 150) begin
        chk("resume_bin150", 32'(bin), 32'h8);
        chk("resume_sel150", 32'(digit_sel), 32'b1011);
      end
    end

    // start+pause together at offset 9: restart wins.
    while (cyc < 162) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    chk("both_run", 32'(running), 32'd1);
    while (cyc < 168) begin
      cycle(1'b0, 1'b0);
      chk("both_run", 32'(running), 32'd1);
      if (cyc == 164) chk("both_bin164", 32'(bin), 32'h1);
      if (cyc == 166) begin
        chk("both_bin166", 32'(bin), 32'h2);
        chk("both_sel166", 32'(digit_sel), 32'b1011);
      end
      if (cyc == 168) begin
        chk("both_bin168", 32'(bin), 32'h4);
        chk("both_sel168", 32'(digit_sel), 32'b0111);
      end
    end

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1 chk_dark("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0);
      chk_dark("post_rst");
    end

`ifdef LETTER_SCROLL_REV_EN
    // Reverse scroll from offset 0: first step wraps to 15.
    dir = 1'b1;
    cycle(1'b1, 1'b0);
    s0 = cyc;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0);
      chk("rev_wrap", 32'(wrap), 32'(cyc == s0 + 4));
    end
`else
    s0 = cyc;
    chk("cycle_count", 32'(s0), 32'd173);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
